udp_frame_builder: RTL and testbench
====================================

Name: udp_frame_builder

Overview:
- Transmit-side counterpart of the PCAP/Ethernet/IPv4/UDP packet parser.
- Takes per-packet header fields and a payload byte stream, and serialises one complete Ethernet II + IPv4 + UDP frame per request.
- Output is a byte stream with valid/ready handshaking; the IPv4 header checksum is computed internally.
- Sits between the payload source (FIFO) and the byte-stream sink (output FIFO or PCAP writer).

Parameters:
MAX_PAYLOAD, 1472, largest accepted UDP payload length in bytes
IP_TTL, 8'h0E, IPv4 time-to-live byte
IP_ID_INIT, 16'h0000, IPv4 identification value of the first frame after reset

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start_valid  in  1  packet request valid
start_ready  out  1  high only in IDLE
start_len  in  16  UDP payload length N, in bytes
dst_mac  in  48  Ethernet destination address
src_mac  in  48  Ethernet source address
src_ip  in  32  IPv4 source address
dst_ip  in  32  IPv4 destination address
src_port  in  16  UDP source port
dst_port  in  16  UDP destination port
in_data  in  8  payload byte
in_valid  in  1  payload byte valid
in_ready  out  1  payload byte accepted when in_valid && in_ready
out_data  out  8  frame byte
out_valid  out  1  frame byte valid
out_ready  in  1  sink accepts the byte
out_sof  out  1  qualifies the first byte of the frame
out_eof  out  1  qualifies the last byte of the frame
len_err  out  1  one-cycle pulse: request rejected
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all outputs 0 except start_ready=1.
  - ip_id=IP_ID_INIT.
  - Any frame in progress is abandoned; no eof is emitted.
- IDLE:
  - On start_valid && start_ready, all header fields and N are latched.
  - If N>MAX_PAYLOAD: pulse len_err, stay in IDLE, ip_id unchanged.
  - Otherwise go to CSUM.
- CSUM (exactly 1 cycle):
  - Checksum = one's-complement of the 16-bit one's-complement sum of the 10 IPv4 header words, with the checksum field taken as 0.
  - IPv4 header fields: total_len=N+28; flags/frag=16'h4000; protocol 8'h11; version/IHL 8'h45; TOS 8'h00.
  - End-around carries are folded fully (two folds).
  - Next state: HDR.
- HDR (42 bytes, big-endian, in this order):
  - dst_mac(6), src_mac(6), 16'h0800.
  - 45, 00, total_len(2), ip_id(2), 40, 00, IP_TTL, 11, checksum(2), src_ip(4), dst_ip(4).
  - src_port(2), dst_port(2), udp_len=N+8 (2), 16'h0000.
  - out_sof is set on byte 0.
  - If N=0, out_eof is set on byte 41 and the next state is IDLE; otherwise the next state is PAYLOAD.
- PAYLOAD:
  - Forwards exactly N bytes from in_data to out_data.
  - out_eof is set on the Nth byte; then go to IDLE.
- Output register:
  - Single stage; loads when !out_valid || out_ready.
  - out_data, out_sof and out_eof are held stable while out_valid && !out_ready.
  - in_ready = (state==PAYLOAD) && (!out_valid || out_ready) && (payload bytes remaining > 0).
  - Full throughput is one byte per cycle.
- Latency: the first out_valid is asserted 2 cycles after the start handshake.
- ip_id increments by 1, modulo 2^16 (wraps 16'hFFFF -> 16'h0000), when the eof byte is accepted.
- Frames are emitted back-to-back; start_ready returns the cycle after the eof byte is accepted.
- No Ethernet minimum-size padding; no FCS.
- Payload stalls (in_valid=0) only deassert out_valid; header content is unaffected.

Optional Feature:
Macro: UDP_PCAP_HDR_EN
- Defined:
  - A 16-byte PCAP packet record header is emitted before the Ethernet header, and out_sof moves to its byte 0.
  - Layout: ts_sec=0, ts_usec=0, incl_len=orig_len=N+42, each 32-bit little-endian.
  - Start-to-first-byte latency is unchanged.
- Undefined: the frame begins with dst_mac; no logic for the record header exists.

Test Plan:
- Case A (N=87): IP_TTL=8'h40, ip_id=0, src_ip=C0A80001, dst_ip=C0A800C7 -> IP bytes 45 00 00 73 00 00 40 00 40 11 B8 61; udp_len=005F; 129 total bytes; sof on byte 0, eof on byte 128.
- N=0 -> 42 bytes; eof on byte 41; in_ready never asserted; udp_len=0008, total_len=001C.
- N=1473 -> len_err pulses one cycle; no out_valid; the next valid request still uses ip_id=IP_ID_INIT.
- Random out_ready (50%) and in_valid gaps on N=64 -> byte sequence identical to the no-stall run; no byte dropped or duplicated.
- Three back-to-back frames -> ip_id 0,1,2; after 65536 frames the id wraps to 0.
- reset_n low mid-payload -> outputs 0 immediately; the next request yields a correct frame with ip_id=IP_ID_INIT.

Source files
------------

// File: rtl/udp_frame_builder_if.sv
// Request, payload-in and frame-out handshake bundle of the UDP frame builder.
`timescale 1ns/1ps
interface udp_frame_builder_if;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] start_len;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic        len_err;
  logic        busy;

  modport slave (
    input  start_valid, start_len, dst_mac, src_mac, src_ip, dst_ip, src_port, dst_port,
    input  in_data, in_valid, out_ready,
    output start_ready, in_ready, out_data, out_valid, out_sof, out_eof, len_err, busy
  );

  modport master (
    output start_valid, start_len, dst_mac, src_mac, src_ip, dst_ip, src_port, dst_port,
    output in_data, in_valid, out_ready,
    input  start_ready, in_ready, out_data, out_valid, out_sof, out_eof, len_err, busy
  );
endinterface

// File: rtl/udp_frame_builder.sv
// Serialises Ethernet II + IPv4 + UDP frames (UDP_PCAP_HDR_EN prepends a PCAP record header).
// Latency: first frame byte valid 2 cycles after the start handshake, then 1 byte/cycle.
// Backpressure: single output register stalls on !out_ready; payload pulled only when it can load.
`timescale 1ns/1ps
module udp_frame_builder #(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter logic [7:0]  IP_TTL      = 8'h0E,
  parameter logic [15:0] IP_ID_INIT  = 16'h0000
) (
  input logic                clock,
  input logic                reset_n,
  udp_frame_builder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CSUM, HDR, PAYLOAD} state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
  } hdr_t;

`ifdef UDP_PCAP_HDR_EN
  localparam int unsigned HDR_LEN = 58;
`else
  localparam int unsigned HDR_LEN = 42;
`endif
  localparam logic [5:0] LAST_IDX = 6'(HDR_LEN - 1);
  localparam logic [5:0] DONE_IDX = 6'(HDR_LEN);

  state_t      state, state_d;
  hdr_t        hdr_q;
  logic [15:0] ip_id, csum_q, csum_c, total_len, udp_len, rem;
  logic [5:0]  idx;
  logic [7:0]  out_data_q;
  logic        out_valid_q, out_sof_q, out_eof_q, len_err_q;
  logic        load_ok, start_fire, len_bad, eof_fire, hdr_ld, pay_ld, in_ready_c;
  logic [19:0] sum_raw;
  logic [16:0] sum_f1;
  logic [15:0] sum_f2;
  logic [335:0] eth_hdr;
  logic [0:HDR_LEN-1][7:0] hdr_bytes;

  assign load_ok    = !out_valid_q || bus.out_ready;
  assign start_fire = bus.start_valid && (state == IDLE);
  assign len_bad    = 32'(bus.start_len) > MAX_PAYLOAD;
  assign eof_fire   = out_valid_q && bus.out_ready && out_eof_q;
  assign in_ready_c = (state == PAYLOAD) && load_ok && (rem != 16'd0);
  assign total_len  = hdr_q.len + 16'd28;
  assign udp_len    = hdr_q.len + 16'd8;

  // Ten header words never exceed 20 bits, so two end-around folds always settle.
  assign sum_raw = 20'(16'h4500) + 20'(total_len) + 20'(ip_id) + 20'(16'h4000)
                 + 20'({IP_TTL, 8'h11})
                 + 20'(hdr_q.src_ip[31:16]) + 20'(hdr_q.src_ip[15:0])
                 + 20'(hdr_q.dst_ip[31:16]) + 20'(hdr_q.dst_ip[15:0]);
  assign sum_f1  = 17'(sum_raw[15:0]) + 17'(sum_raw[19:16]);
  assign sum_f2  = sum_f1[15:0] + 16'(sum_f1[16]);
  assign csum_c  = ~sum_f2;

  assign eth_hdr = {hdr_q.dst_mac, hdr_q.src_mac, 16'h0800,
                    8'h45, 8'h00, total_len, ip_id, 8'h40, 8'h00, IP_TTL, 8'h11, csum_q,
                    hdr_q.src_ip, hdr_q.dst_ip,
                    hdr_q.src_port, hdr_q.dst_port, udp_len, 16'h0000};

`ifdef UDP_PCAP_HDR_EN
  logic [15:0] rec_len;
  assign rec_len   = hdr_q.len + 16'd42;
  assign hdr_bytes = {64'h0, rec_len[7:0], rec_len[15:8], 16'h0000,
                      rec_len[7:0], rec_len[15:8], 16'h0000, eth_hdr};
`else
  assign hdr_bytes = eth_hdr;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    hdr_ld  = 1'b0;
    pay_ld  = 1'b0;
    case (state)
      IDLE: if (start_fire && !len_bad) state_d = CSUM;
      CSUM: state_d = HDR;
      HDR: begin
        hdr_ld = load_ok && (idx != DONE_IDX);
        if (hdr_ld && (idx == LAST_IDX) && (hdr_q.len != 16'd0)) state_d = PAYLOAD;
        if (eof_fire) state_d = IDLE;
      end
      PAYLOAD: begin
        pay_ld = bus.in_valid && in_ready_c;
        if (eof_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q       <= '0;
      rem         <= '0;
      idx         <= '0;
      csum_q      <= '0;
      ip_id       <= IP_ID_INIT;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      len_err_q <= start_fire && len_bad;
      if (start_fire) begin
        hdr_q <= '{dst_mac: bus.dst_mac, src_mac: bus.src_mac, src_ip: bus.src_ip,
                   dst_ip: bus.dst_ip, src_port: bus.src_port, dst_port: bus.dst_port,
                   len: bus.start_len};
        rem   <= bus.start_len;
        idx   <= '0;
      end
      if (state == CSUM) csum_q <= csum_c;
      if (eof_fire) ip_id <= ip_id + 16'd1;
      // Idle slots clear valid only when the held byte has left the register.
      if (hdr_ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= hdr_bytes[idx];
        out_sof_q   <= (idx == 6'd0);
        out_eof_q   <= (idx == LAST_IDX) && (hdr_q.len == 16'd0);
        idx         <= idx + 6'd1;
      end else if (pay_ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data;
        out_sof_q   <= 1'b0;
        out_eof_q   <= (rem == 16'd1);
        rem         <= rem - 16'd1;
      end else if (load_ok) begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.in_ready    = in_ready_c;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sof     = out_sof_q;
  assign bus.out_eof     = out_eof_q;
  assign bus.len_err     = len_err_q;
endmodule

// File: tb/tb_udp_frame_builder.sv
// Randomised scoreboard bench for udp_frame_builder against a byte-list frame model.
`timescale 1ns/1ps
module tb_udp_frame_builder;
  localparam logic [7:0] TTL  = 8'h40;
  localparam int         MAXP = 1472;
`ifdef UDP_PCAP_HDR_EN
  localparam int ETH = 16;
`else
  localparam int ETH = 0;
`endif

  typedef struct {
    logic [47:0] dmac, smac;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
  } req_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  udp_frame_builder_if bus();
  udp_frame_builder_if bus2();

  udp_frame_builder #(.IP_TTL(TTL)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  udp_frame_builder #(.IP_TTL(TTL), .IP_ID_INIT(16'hFFFF)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  int          total = 0;
  int          bad = 0;
  int          in_rdy_cnt = 0;
  bit          stall_en = 0, gap_en = 0, in_fire = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  pay_q[$];
  logic [7:0]  cap_q[$];
  logic [7:0]  mdl_q[$];
  logic [7:0]  none_q[$];
  logic [15:0] mdl_id = 16'h0000;
  logic [7:0]  ipa [12] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00,
                            8'h40, 8'h00, 8'h40, 8'h11, 8'hB8, 8'h61};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic void put(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) mdl_q.push_back(v[8*i +: 8]);
  endfunction

  // Reference frame as a plain list of bytes, checksum by repeated folding.
  function automatic void model_frame(input req_t r, input int n, input logic [15:0] id,
                                      input logic [7:0] pay[$]);
    logic [15:0] w [10];
    int s;
    mdl_q.delete();
`ifdef UDP_PCAP_HDR_EN
    put(64'd0, 8);
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++) mdl_q.push_back(8'((n + 42) >> (8 * b)));
`endif
    put(64'(r.dmac), 6);
    put(64'(r.smac), 6);
    put(64'h0800, 2);
    w = '{16'h4500, 16'(n + 28), id, 16'h4000, {TTL, 8'h11}, 16'h0000,
          r.sip[31:16], r.sip[15:0], r.dip[31:16], r.dip[15:0]};
    s = 0;
    foreach (w[i]) s += int'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    w[5] = ~16'(s);
    foreach (w[i]) put(64'(w[i]), 2);
    put(64'(r.sp), 2);
    put(64'(r.dp), 2);
    put(64'(n + 8), 2);
    put(64'd0, 2);
    foreach (pay[i]) mdl_q.push_back(pay[i]);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.dmac = {16'($urandom()), $urandom()};
    r.smac = {16'($urandom()), $urandom()};
    r.sip  = $urandom();
    r.dip  = $urandom();
    r.sp   = 16'($urandom());
    r.dp   = 16'($urandom());
    return r;
  endfunction

  task automatic send(input req_t r, input int n);
    logic [7:0] pay[$];
    logic v0, v1, v2, e0, e1;
    int g = 0;
    while (!bus.start_ready && g < 20000) begin @(posedge clock); #1; g++; end
    if (!bus.start_ready) begin
      total++; bad++;
      $display("FAIL start_wait: start_ready=0 want 1");
      return;
    end
    bus.dst_mac = r.dmac; bus.src_mac = r.smac; bus.src_ip = r.sip; bus.dst_ip = r.dip;
    bus.src_port = r.sp; bus.dst_port = r.dp; bus.start_len = 16'(n); bus.start_valid = 1'b1;
    if (n <= MAXP) begin
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom()));
      model_frame(r, n, mdl_id, pay);
      foreach (mdl_q[i]) exp_q.push_back('{d: mdl_q[i], sof: (i == 0), eof: (i == mdl_q.size() - 1)});
      foreach (pay[i]) pay_q.push_back(pay[i]);
      mdl_id++;
    end
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    @(negedge clock); v0 = bus.out_valid; e0 = bus.len_err;
    @(negedge clock); v1 = bus.out_valid; e1 = bus.len_err;
    @(negedge clock); v2 = bus.out_valid;
    if (n <= MAXP) chk("latency", 64'({v0, v1, v2}), 64'(3'b001));
    else chk("len_err", 64'({e0, e1, v0, v1, v2, bus.busy}), 64'(6'b100000));
    @(posedge clock); #1;
  endtask

  task automatic wait_done();
    int g = 0;
    while ((exp_q.size() != 0 || !bus.start_ready) && g < 20000) begin @(posedge clock); #1; g++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every accepted byte is popped and compared.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus.in_ready) in_rdy_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        cap_q.push_back(bus.out_data);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h want none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_byte", 64'({bus.out_sof, bus.out_eof, bus.out_data}),
              64'({mon_e.sof, mon_e.eof, mon_e.d}));
        end
      end
    end
  end

  // Payload source and sink-ready driver.
  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    forever begin
      @(negedge clock);
      in_fire = bus.in_valid && bus.in_ready;
      @(posedge clock); #1;
      if (in_fire && pay_q.size() > 0) void'(pay_q.pop_front());
      bus.in_valid  = (pay_q.size() > 0) && (!gap_en || $urandom_range(0, 2) != 0);
      bus.in_data   = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
      bus.out_ready = !stall_en || ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    req_t r;
    int n, g, mism;
    logic [15:0] id;
    logic [7:0] got[$];
    bus.start_valid = 1'b0; bus.start_len = '0; bus.dst_mac = '0; bus.src_mac = '0;
    bus.src_ip = '0; bus.dst_ip = '0; bus.src_port = '0; bus.dst_port = '0;
    bus2.start_valid = 1'b0; bus2.start_len = '0; bus2.in_valid = 1'b0; bus2.in_data = '0;
    bus2.out_ready = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 chk("reset_state", 64'({bus.start_ready, bus.busy, bus.out_valid, bus.in_ready,
                               bus.len_err, bus.out_sof, bus.out_eof}), 64'(7'b1000000));
    #19 reset_n = 1'b1;
    @(posedge clock); #1;

    // Oversized request first: it must not consume an id.
    cap_q.delete();
    send(rand_req(), MAXP + 1);
    repeat (5) @(posedge clock);
    #1 chk("len_err_no_out", 64'(cap_q.size()), 64'd0);

    r = rand_req(); r.sip = 32'hC0A80001; r.dip = 32'hC0A800C7;
    cap_q.delete();
    send(r, 87);
    wait_done();
    chk("caseA_size", 64'(cap_q.size()), 64'(129 + ETH));
    for (int i = 0; i < 12; i++) chk("caseA_ip", 64'(cap_q[ETH + 14 + i]), 64'(ipa[i]));
    chk("caseA_udp_len", 64'({cap_q[ETH + 38], cap_q[ETH + 39]}), 64'h005F);

    cap_q.delete(); in_rdy_cnt = 0;
    send(rand_req(), 0);
    wait_done();
    chk("n0_size", 64'(cap_q.size()), 64'(42 + ETH));
    chk("n0_total_len", 64'({cap_q[ETH + 16], cap_q[ETH + 17]}), 64'h001C);
    chk("n0_udp_len", 64'({cap_q[ETH + 38], cap_q[ETH + 39]}), 64'h0008);
    chk("n0_in_ready", 64'(in_rdy_cnt), 64'd0);

    for (int k = 0; k < 3; k++) send(rand_req(), $urandom_range(1, 40));
    wait_done();

    stall_en = 1; gap_en = 1;
    cap_q.delete();
    send(rand_req(), 64);
    wait_done();
    chk("stall_size", 64'(cap_q.size()), 64'(64 + 42 + ETH));
    for (int k = 0; k < 12; k++) begin
      n = ($urandom_range(0, 5) == 0) ? MAXP + 1 + $urandom_range(0, 200) : $urandom_range(0, 120);
      send(rand_req(), n);
    end
    wait_done();
    stall_en = 0; gap_en = 0;
    send(rand_req(), MAXP);
    wait_done();

    send(rand_req(), 64);
    repeat (60) @(posedge clock);
    #4 chk("mid_busy", 64'({bus.busy, pay_q.size() > 0}), 64'(2'b11));
    reset_n = 1'b0;
    exp_q.delete(); pay_q.delete(); mdl_id = 16'h0000;
    #1 chk("reset_mid", 64'({bus.start_ready, bus.busy, bus.out_valid, bus.in_ready,
                             bus.len_err, bus.out_sof, bus.out_eof}), 64'(7'b1000000));
    #20 reset_n = 1'b1;
    @(posedge clock); #1;
    cap_q.delete();
    send(rand_req(), 5);
    wait_done();
    chk("post_reset_id", 64'({cap_q[ETH + 18], cap_q[ETH + 19]}), 64'h0000);

    // Id wrap on the instance that starts at FFFF.
    r = rand_req();
    bus2.dst_mac = r.dmac; bus2.src_mac = r.smac; bus2.src_ip = r.sip; bus2.dst_ip = r.dip;
    bus2.src_port = r.sp; bus2.dst_port = r.dp;
    for (int f = 0; f < 3; f++) begin
      id = 16'hFFFF + 16'(f);
      got.delete(); g = 0; mism = 0;
      while (!bus2.start_ready && g < 100) begin @(posedge clock); #1; g++; end
      bus2.start_valid = 1'b1;
      @(posedge clock); #1;
      bus2.start_valid = 1'b0;
      g = 0;
      while (g < 200) begin
        @(negedge clock); g++;
        if (bus2.out_valid) begin
          got.push_back(bus2.out_data);
          if (bus2.out_eof) break;
        end
      end
      @(posedge clock); #1;
      model_frame(r, 0, id, none_q);
      chk("wrap_size", 64'(got.size()), 64'(mdl_q.size()));
      foreach (mdl_q[i]) if (i >= got.size() || got[i] !== mdl_q[i]) mism++;
      chk("wrap_bytes", 64'(mism), 64'd0);
      chk("wrap_id", 64'({got[ETH + 18], got[ETH + 19]}), 64'(id));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
